// File: rtl/spi_request_arbiter.sv
// spi_request_arbiter
// Shares one spi_logic_master between NREQ requesters (CPU core, DMA, boot
// loader) on the clk_cpu domain. Requesters are served round-robin. The granted
// requester's bitrate, TX word and control word are registered onto the master
// inputs. The arbiter then pulses the start bit and waits for a fresh rising
// edge of IRQ_SPI. The received word is returned with a one-cycle done pulse.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to bound the time spent waiting
// for IRQ_SPI to TIMEOUT cycles. An expired transfer completes with err=1 and
// rd_data=0. Without the macro there is no counter and err is tied low.
//
// Timing, counted in clk_cpu cycles:
//   req seen in IDLE (cycle 0) -> ARB (1) -> LOAD (2) -> START bit high (3).
//   IRQ_SPI rise seen in WAIT (cycle 0) -> DONE (1) -> done pulse (2).
// The done pulse is registered out of DONE. It therefore appears in the cycle
// after DONE, while the FSM is already back in IDLE. gnt is held through that
// cycle, so done is always accompanied by the matching grant.

module spi_request_arbiter #(
   parameter int NREQ      = 2,
   parameter int START_BIT = 0,
   parameter int TIMEOUT   = 65535
) (
   input  logic                clk_cpu,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*32-1:0]  req_bitrate,
   input  logic [NREQ*32-1:0]  req_data,
   input  logic [NREQ*9-1:0]   req_ctrl,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     done,
   output logic                err,
   output logic [31:0]         rd_data,
   output logic                busy,
   output logic [31:0]         SPI_BITRATE,
   output logic [31:0]         SPI_DATA_OUT,
   output logic [8:0]          SPI_CTRL,
   input  logic [31:0]         SPI_DATA_IN,
   input  logic                IRQ_SPI
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [IW-1:0]   idx;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   rr_next;
   logic            irq_q;
   logic            complete;
   logic            timeout_hit;

   logic            pick_found;
   logic [IW-1:0]   pick_idx;
   int              cand;

   logic [31:0]     bitrate_pick;
   logic [31:0]     data_pick;
   logic [8:0]      ctrl_pick;

   // A completion is a fresh rising edge of IRQ_SPI seen while waiting.
   // A level that is already high on entry to WAIT is not a completion.
   assign complete = (state == ST_WAIT) && IRQ_SPI && !irq_q;

   assign busy = (state != ST_IDLE);

   // The pointer advances past the requester just served.
   assign rr_next = (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);

   // Round-robin search: first set request at or after rr_ptr, wrapping mod NREQ
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         for (int j = 0; j < NREQ; j++) begin
            if (!pick_found && (cand == j) && req[j]) begin
               pick_found = 1'b1;
               pick_idx   = IW'(j);
            end
         end
      end
   end

   // Select the chosen requester's words; the start bit is forced low for setup
   always_comb begin
      bitrate_pick = '0;
      data_pick    = '0;
      ctrl_pick    = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick_idx == IW'(k)) begin
            bitrate_pick = req_bitrate[k*32 +: 32];
            data_pick    = req_data[k*32 +: 32];
            ctrl_pick    = req_ctrl[k*9 +: 9];
         end
      end
      ctrl_pick[START_BIT] = 1'b0;
   end

   // FSM state register
   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (|req) begin
               state_next = ST_ARB;
            end
         end
         ST_ARB: begin
            state_next = pick_found ? ST_LOAD : ST_IDLE;
         end
         ST_LOAD: begin
            state_next = ST_START;
         end
         ST_START: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (complete || timeout_hit) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Grant, master-side registers, read data, done pulse and rr pointer
   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         idx          <= '0;
         rr_ptr       <= '0;
         irq_q        <= 1'b0;
         gnt          <= '0;
         done         <= '0;
         rd_data      <= '0;
         SPI_BITRATE  <= '0;
         SPI_DATA_OUT <= '0;
         SPI_CTRL     <= '0;
      end else begin
         irq_q <= IRQ_SPI;
         done  <= '0;
         case (state)
            ST_IDLE: begin
               gnt <= '0;
            end
            ST_ARB: begin
               if (pick_found) begin
                  idx          <= pick_idx;
                  gnt          <= NREQ'(1) << pick_idx;
                  SPI_BITRATE  <= bitrate_pick;
                  SPI_DATA_OUT <= data_pick;
                  SPI_CTRL     <= ctrl_pick;
               end
            end
            ST_LOAD: begin
               SPI_CTRL[START_BIT] <= 1'b1;
            end
            ST_WAIT: begin
               if (complete) begin
                  rd_data             <= SPI_DATA_IN;
                  SPI_CTRL[START_BIT] <= 1'b0;
               end else if (timeout_hit) begin
                  rd_data             <= '0;
                  SPI_CTRL[START_BIT] <= 1'b0;
               end
            end
            ST_DONE: begin
               done   <= gnt;
               rr_ptr <= rr_next;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   logic [31:0] wait_cnt;
   logic        timed_out;
   logic        err_q;

   // wait_cnt equals the number of cycles already spent in WAIT.
   // WAIT is left one cycle early because done and err are registered out of
   // DONE, so they appear exactly TIMEOUT cycles after entering WAIT.
   // TIMEOUT must be at least 2.
   assign timeout_hit = (state == ST_WAIT) && (wait_cnt == 32'(TIMEOUT - 2));
   assign err         = err_q;

   // Wait-cycle counter and the timeout flag carried into the done pulse
   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         wait_cnt  <= '0;
         timed_out <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            ST_START: begin
               wait_cnt  <= '0;
               timed_out <= 1'b0;
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt + 32'd1;
               if (!complete && timeout_hit) begin
                  timed_out <= 1'b1;
               end
            end
            ST_DONE: begin
               err_q     <= timed_out;
               timed_out <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_request_arbiter.sv
// tb_spi_request_arbiter
// Directed bench for spi_request_arbiter with NREQ=2 and START_BIT=0.
// Covers reset state, round-robin order, latencies, the IRQ edge rule, reset
// during a transfer and holding of the master-side words. When compiled with
// SPI_ARB_TIMEOUT_EN it also covers the timeout path with TIMEOUT=50.
`timescale 1ns/1ps

module tb_spi_request_arbiter;

   localparam int NREQ = 2;

   logic                clk_cpu = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [NREQ*32-1:0]  req_bitrate;
   logic [NREQ*32-1:0]  req_data;
   logic [NREQ*9-1:0]   req_ctrl;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     done;
   logic                err;
   logic [31:0]         rd_data;
   logic                busy;
   logic [31:0]         SPI_BITRATE;
   logic [31:0]         SPI_DATA_OUT;
   logic [8:0]          SPI_CTRL;
   logic [31:0]         SPI_DATA_IN;
   logic                IRQ_SPI;

   int checkCount = 0;
   int errorCount = 0;
   int donePulses = 0;
   int pulseSnap  = 0;

   spi_request_arbiter #(
      .NREQ      (NREQ),
      .START_BIT (0),
      .TIMEOUT   (50)
   ) dut (
      .clk_cpu      (clk_cpu),
      .rst          (rst),
      .req          (req),
      .req_bitrate  (req_bitrate),
      .req_data     (req_data),
      .req_ctrl     (req_ctrl),
      .gnt          (gnt),
      .done         (done),
      .err          (err),
      .rd_data      (rd_data),
      .busy         (busy),
      .SPI_BITRATE  (SPI_BITRATE),
      .SPI_DATA_OUT (SPI_DATA_OUT),
      .SPI_CTRL     (SPI_CTRL),
      .SPI_DATA_IN  (SPI_DATA_IN),
      .IRQ_SPI      (IRQ_SPI)
   );

   // 100 MHz clk_cpu
   always #5 clk_cpu = ~clk_cpu;

   // Count every cycle carrying a done pulse, sampled away from the active edge
   always @(negedge clk_cpu) begin
      if (|done) begin
         donePulses++;
      end
   end

   // Hard stop in case something hangs
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk_cpu);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Load one requester's bitrate, TX word and control word
   task automatic applyStimulus(input int r, input logic [31:0] bitrate,
                                input logic [31:0] data, input logic [8:0] ctrl);
      if (r == 0) begin
         req_bitrate[31:0] = bitrate;
         req_data[31:0]    = data;
         req_ctrl[8:0]     = ctrl;
      end else begin
         req_bitrate[63:32] = bitrate;
         req_data[63:32]    = data;
         req_ctrl[17:9]     = ctrl;
      end
   endtask

   // Wait for the start bit, with a bounded number of cycles
   task automatic waitStart(input string tag);
      for (int n = 0; n < 20 && SPI_CTRL[0] == 1'b0; n++) tick();
      checkOutput(tag, SPI_CTRL[0], 1'b1);
   endtask

   // One full transfer while req is held. On return the FSM sits in the cycle
   // after the done pulse.
   task automatic doTransfer(input string tag, input logic [1:0] exp_gnt,
                             input logic [31:0] exp_tx, input logic [31:0] rx_word);
      for (int n = 0; n < 20 && gnt == 2'b00; n++) tick();
      checkOutput({tag, " gnt"}, gnt, exp_gnt);
      checkOutput({tag, " tx"}, SPI_DATA_OUT, exp_tx);
      waitStart({tag, " start"});
      repeat (3) tick();
      SPI_DATA_IN = rx_word;
      IRQ_SPI     = 1'b1;
      tick();
      IRQ_SPI = 1'b0;
      tick();
      checkOutput({tag, " done"}, done, exp_gnt);
      checkOutput({tag, " rdata"}, rd_data, rx_word);
      tick();
      checkOutput({tag, " done gone"}, done, 2'b00);
   endtask

   initial begin
      rst         = 1'b1;
      req         = '0;
      req_bitrate = '0;
      req_data    = '0;
      req_ctrl    = '0;
      SPI_DATA_IN = '0;
      IRQ_SPI     = 1'b0;
      tick();
      tick();

      // Reset state
      checkOutput("reset gnt", gnt, 2'b00);
      checkOutput("reset done", done, 2'b00);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset ctrl", SPI_CTRL, 9'h000);
      checkOutput("reset txdata", SPI_DATA_OUT, 32'h0);
      checkOutput("reset rd_data", rd_data, 32'h0);
      checkOutput("reset err", err, 1'b0);
      rst = 1'b0;
      tick();

      applyStimulus(0, 32'd4, 32'hA5A5_0F0F, 9'h0A5);
      applyStimulus(1, 32'd8, 32'h1111_2222, 9'h100);

      // Both requesters held: grants alternate starting from requester 0
      $display("[TB] round-robin with req=11");
      pulseSnap = donePulses;
      req = 2'b11;
      doTransfer("rr0", 2'b01, 32'hA5A5_0F0F, 32'h0000_00A0);
      doTransfer("rr1", 2'b10, 32'h1111_2222, 32'h0000_00A1);
      doTransfer("rr2", 2'b01, 32'hA5A5_0F0F, 32'h0000_00A2);
      doTransfer("rr3", 2'b10, 32'h1111_2222, 32'h0000_00A3);
      req = 2'b00;
      repeat (3) tick();
      checkOutput("rr pulse count", donePulses - pulseSnap, 4);
      checkOutput("rr idle busy", busy, 1'b0);

      // Single requester 0 with latency and hold checks
      $display("[TB] single transfer from requester 0");
      req = 2'b01;
      tick();
      checkOutput("t1 arb busy", busy, 1'b1);
      checkOutput("t1 arb gnt", gnt, 2'b00);
      tick();
      checkOutput("t1 load gnt", gnt, 2'b01);
      checkOutput("t1 load bitrate", SPI_BITRATE, 32'd4);
      checkOutput("t1 load txdata", SPI_DATA_OUT, 32'hA5A5_0F0F);
      checkOutput("t1 load ctrl", SPI_CTRL, 9'h0A4);
      tick();
      checkOutput("t1 start ctrl", SPI_CTRL, 9'h0A5);
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (n == 5) req_data[31:0] = 32'hDEAD_BEEF;
      end
      checkOutput("t1 wait done", done, 2'b00);
      checkOutput("t1 wait txdata held", SPI_DATA_OUT, 32'hA5A5_0F0F);
      checkOutput("t1 wait ctrl", SPI_CTRL, 9'h0A5);
      SPI_DATA_IN = 32'h1234_5678;
      IRQ_SPI     = 1'b1;
      tick();
      checkOutput("t1 done state no pulse yet", done, 2'b00);
      checkOutput("t1 done state start low", SPI_CTRL, 9'h0A4);
      tick();
      checkOutput("t1 done pulse", done, 2'b01);
      checkOutput("t1 rd_data", rd_data, 32'h1234_5678);
      checkOutput("t1 err", err, 1'b0);
      checkOutput("t1 gnt with done", gnt, 2'b01);
      req     = 2'b00;
      IRQ_SPI = 1'b0;
      tick();
      checkOutput("t1 after done", done, 2'b00);
      checkOutput("t1 after gnt", gnt, 2'b00);
      checkOutput("t1 after busy", busy, 1'b0);
      req_data[31:0] = 32'hA5A5_0F0F;
      tick();

      // IRQ_SPI already high before START; only the later rising edge completes.
      // req is also dropped mid-transfer and the done pulse must still arrive.
      $display("[TB] stale IRQ level and req drop");
      pulseSnap   = donePulses;
      SPI_DATA_IN = 32'hCAFE_F00D;
      IRQ_SPI     = 1'b1;
      req         = 2'b01;
      waitStart("t3 start");
      repeat (5) tick();
      checkOutput("t3 stale irq done", done, 2'b00);
      checkOutput("t3 stale irq still started", SPI_CTRL[0], 1'b1);
      IRQ_SPI = 1'b0;
      req     = 2'b00;
      repeat (10) tick();
      checkOutput("t3 still waiting", busy, 1'b1);
      IRQ_SPI = 1'b1;
      tick();
      tick();
      checkOutput("t3 done on fresh edge", done, 2'b01);
      checkOutput("t3 rd_data", rd_data, 32'hCAFE_F00D);
      IRQ_SPI = 1'b0;
      tick();
      checkOutput("t3 single pulse", donePulses - pulseSnap, 1);

      // Reset while in WAIT; the pointer must restart at requester 0
      $display("[TB] reset during WAIT");
      req = 2'b01;
      waitStart("t4 start");
      tick();
      tick();
      pulseSnap = donePulses;
      rst       = 1'b1;
      req       = 2'b00;
      tick();
      rst = 1'b0;
      checkOutput("t4 gnt", gnt, 2'b00);
      checkOutput("t4 done", done, 2'b00);
      checkOutput("t4 busy", busy, 1'b0);
      checkOutput("t4 ctrl", SPI_CTRL, 9'h000);
      checkOutput("t4 txdata", SPI_DATA_OUT, 32'h0);
      checkOutput("t4 bitrate", SPI_BITRATE, 32'h0);
      checkOutput("t4 rd_data", rd_data, 32'h0);
      IRQ_SPI = 1'b1;
      tick();
      tick();
      IRQ_SPI = 1'b0;
      tick();
      checkOutput("t4 no done", donePulses - pulseSnap, 0);
      req = 2'b11;
      doTransfer("t4 post", 2'b01, 32'hA5A5_0F0F, 32'h0BAD_CAFE);
      req = 2'b00;
      tick();
      tick();

`ifdef SPI_ARB_TIMEOUT_EN
      // IRQ_SPI never rises; done and err arrive 50 cycles after entering WAIT
      $display("[TB] timeout");
      req = 2'b01;
      waitStart("t5 start");
      tick();
      for (int n = 1; n <= 49; n++) tick();
      checkOutput("t5 early done", done, 2'b00);
      tick();
      checkOutput("t5 done", done, 2'b01);
      checkOutput("t5 err", err, 1'b1);
      checkOutput("t5 rd_data", rd_data, 32'h0);
      req = 2'b00;
      tick();
      checkOutput("t5 err cleared", err, 1'b0);
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
